// File: rtl/icache_core_pkg.sv
// Shared widths, line type, state encoding and address-field helpers for the
// 2-way set-associative instruction cache.
package icache_core_pkg;

    localparam int SETS       = 64;
    localparam int LINE_WORDS = 8;
    localparam int BlockNum   = LINE_WORDS;
    localparam int LINE_BITS  = 32 * LINE_WORDS;
    localparam int OFF_W      = $clog2(BlockNum);
    localparam int IDX_W      = $clog2(SETS);
    localparam int TAG_W      = 32 - IDX_W - 5;
    localparam int LINE_W     = 32 - 5;

    typedef logic [LINE_BITS-1:0] WayBus;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [OFF_W-1:0]     off_t;

    typedef enum logic [3:0] {
        LOOKUP    = 4'b0001,
        MISS_WAIT = 4'b0010,
        REFILL    = 4'b0100,
        RESP      = 4'b1000
    } state_e;

    function automatic idx_t addr_idx(input logic [31:0] addr);
        return addr[5 +: IDX_W];
    endfunction

    function automatic tag_t addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic off_t addr_off(input logic [31:0] addr);
        return addr[2 +: OFF_W];
    endfunction

    function automatic logic [31:0] line_word(input WayBus line, input off_t off);
        return line[32 * int'(off) +: 32];
    endfunction

endpackage

// File: rtl/icache_core_if.sv
// Fetch-side and refill-side signals of the icache; the core uses the slave
// modport, the IF stage / refill engine side uses master.
interface icache_core_if;
    import icache_core_pkg::*;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_cached_i;
    logic        if_stall_i;
    logic [31:0] if_rdata_o;
    logic        if_rvalid_o;
    logic        icache_stall_o;
    logic        inv_all_i;
    logic        axi_req_o;
    logic [31:0] axi_addr_o;
    logic        axi_rend_i;
    WayBus       axi_data_i;
    logic        dcache_active_i;

    modport slave (
        input  if_req_i, if_addr_i, if_cached_i, if_stall_i, inv_all_i,
               axi_rend_i, axi_data_i, dcache_active_i,
        output if_rdata_o, if_rvalid_o, icache_stall_o, axi_req_o, axi_addr_o
    );

    modport master (
        output if_req_i, if_addr_i, if_cached_i, if_stall_i, inv_all_i,
               axi_rend_i, axi_data_i, dcache_active_i,
        input  if_rdata_o, if_rvalid_o, icache_stall_o, axi_req_o, axi_addr_o
    );

endinterface

// File: rtl/icache_core_way.sv
// One cache way: flop-based valid/tag/data arrays with combinational lookup,
// a whole-line write port and a flash invalidate.
module icache_core_way
    import icache_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  idx_t        rd_idx_i,
    input  tag_t        rd_tag_i,
    input  off_t        rd_off_i,
    output logic        hit_o,
    output logic        valid_o,
    output logic [31:0] word_o,
    input  logic        wr_en_i,
    input  idx_t        wr_idx_i,
    input  tag_t        wr_tag_i,
    input  WayBus       wr_data_i,
    input  logic        inv_all_i
);

    logic [SETS-1:0] valid_q, valid_d;
    tag_t            tag_q  [SETS];
    tag_t            tag_d  [SETS];
    WayBus           data_q [SETS];
    WayBus           data_d [SETS];

    // Invalidate wins over a same-cycle fill: the line lands but stays invalid.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
            tag_d[wr_idx_i]   = wr_tag_i;
            data_d[wr_idx_i]  = wr_data_i;
        end
        if (inv_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign valid_o = valid_q[rd_idx_i];
    assign hit_o   = valid_o && (tag_q[rd_idx_i] == rd_tag_i);
    assign word_o  = line_word(data_q[rd_idx_i], rd_off_i);

endmodule

// File: rtl/icache_core.sv
// Instruction cache front end: same-cycle hits, single outstanding line refill
// through the AXI refill engine, per-set 1-bit LRU replacement.
module icache_core
    import icache_core_pkg::*;
(
    input logic          aclk,
    input logic          areset,
    icache_core_if.slave bus
);

    state_e             state_q, state_d;
    logic [SETS-1:0]    lru_q, lru_d;
    logic [LINE_W-1:0]  line_q, line_d;
    off_t               off_q, off_d;
    logic               victim_q, victim_d;
    logic [31:0]        resp_q, resp_d;
    logic               axi_req_q, axi_req_d;

    logic [1:0]         way_hit;
    logic [1:0]         way_valid;
    logic [1:0]         way_wr;
    logic [31:0]        way_word [2];

    idx_t  req_idx;
    tag_t  req_tag;
    off_t  req_off;
    idx_t  fill_idx;
    tag_t  fill_tag;
    logic  lookup_ok, hit, miss, hit_way, victim;

    assign req_idx  = addr_idx(bus.if_addr_i);
    assign req_tag  = addr_tag(bus.if_addr_i);
    assign req_off  = addr_off(bus.if_addr_i);
    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[LINE_W-1:IDX_W];

    // Lookups only happen in LOOKUP, so a fill and a hit never touch LRU together.
    assign lookup_ok = (state_q == LOOKUP) && bus.if_req_i && bus.if_cached_i;
    assign hit       = lookup_ok && (|way_hit);
    assign miss      = lookup_ok && !(|way_hit);
    assign hit_way   = way_hit[1];
    assign victim    = !way_valid[0] ? 1'b0 :
                       !way_valid[1] ? 1'b1 : lru_q[req_idx];

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign way_wr[w] = (state_q == REFILL) && bus.axi_rend_i && (victim_q == 1'(w));

        icache_core_way u_way (
            .clk       (aclk),
            .rst       (areset),
            .rd_idx_i  (req_idx),
            .rd_tag_i  (req_tag),
            .rd_off_i  (req_off),
            .hit_o     (way_hit[w]),
            .valid_o   (way_valid[w]),
            .word_o    (way_word[w]),
            .wr_en_i   (way_wr[w]),
            .wr_idx_i  (fill_idx),
            .wr_tag_i  (fill_tag),
            .wr_data_i (bus.axi_data_i),
            .inv_all_i (bus.inv_all_i)
        );
    end

    always_comb begin
        state_d   = state_q;
        lru_d     = lru_q;
        line_d    = line_q;
        off_d     = off_q;
        victim_d  = victim_q;
        resp_d    = resp_q;
        axi_req_d = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (hit) begin
                    lru_d[req_idx] = ~hit_way;
                end else if (miss) begin
                    line_d   = bus.if_addr_i[31:5];
                    off_d    = req_off;
                    victim_d = victim;
                    if (!bus.dcache_active_i) begin
                        axi_req_d = 1'b1;
                        state_d   = REFILL;
                    end else begin
                        state_d   = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                if (!bus.dcache_active_i) begin
                    axi_req_d = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                if (bus.axi_rend_i) begin
                    lru_d[fill_idx] = ~victim_q;
                    resp_d          = line_word(bus.axi_data_i, off_q);
                    state_d         = RESP;
                end
            end
            RESP: begin
                if (!bus.if_stall_i) begin
                    state_d = LOOKUP;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= LOOKUP;
            lru_q     <= '0;
            line_q    <= '0;
            off_q     <= '0;
            victim_q  <= 1'b0;
            resp_q    <= '0;
            axi_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lru_q     <= lru_d;
            line_q    <= line_d;
            off_q     <= off_d;
            victim_q  <= victim_d;
            resp_q    <= resp_d;
            axi_req_q <= axi_req_d;
        end
    end

    assign bus.if_rvalid_o    = hit || (state_q == RESP);
    assign bus.if_rdata_o     = (state_q == RESP) ? resp_q :
                                hit ? way_word[hit_way] : 32'h0;
    assign bus.icache_stall_o = miss || (state_q == MISS_WAIT) || (state_q == REFILL);
    assign bus.axi_req_o      = axi_req_q;
    assign bus.axi_addr_o     = {line_q, 5'b0};

endmodule

// File: tb/tb_icache_core.sv
// Directed bench for icache_core: the bench plays IF stage and refill engine,
// expected words are built from the line pattern base + word index.
module tb_icache_core;
    import icache_core_pkg::*;

    logic aclk = 1'b0;
    logic areset;
    int   vectors = 0;
    int   miscompares = 0;

    icache_core_if bus ();

    icache_core dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr);
        bus.if_req_i    = req;
        bus.if_addr_i   = addr;
        bus.if_cached_i = 1'b1;
    endtask

    function automatic WayBus makeLine(input logic [31:0] base);
        WayBus l;
        for (int k = 0; k < LINE_WORDS; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic doHit(input logic [31:0] addr, input logic [31:0] expWord);
        applyStimulus(1'b1, addr);
        #1;
        checkOutput("hitValid", 32'(bus.if_rvalid_o), 32'd1);
        checkOutput("hitData", bus.if_rdata_o, expWord);
        checkOutput("hitNoStall", 32'(bus.icache_stall_o), 32'd0);
        tick();
        checkOutput("hitNoAxiReq", 32'(bus.axi_req_o), 32'd0);
        applyStimulus(1'b0, addr);
    endtask

    task automatic doMiss(input logic [31:0] addr, input logic [31:0] base,
                          input int dcCycles, input bit invAtRend, input int holdCycles);
        logic [31:0] expWord;
        expWord = base + 32'(addr[4:2]);
        bus.dcache_active_i = (dcCycles > 0);
        applyStimulus(1'b1, addr);
        #1;
        checkOutput("missStall", 32'(bus.icache_stall_o), 32'd1);
        checkOutput("missNoValid", 32'(bus.if_rvalid_o), 32'd0);
        tick();
        if (dcCycles > 0) begin
            for (int c = 1; c < dcCycles; c++) begin
                #1;
                checkOutput("waitStall", 32'(bus.icache_stall_o), 32'd1);
                checkOutput("waitNoReq", 32'(bus.axi_req_o), 32'd0);
                tick();
            end
            bus.dcache_active_i = 1'b0;
            #1;
            checkOutput("waitDropStall", 32'(bus.icache_stall_o), 32'd1);
            tick();
        end
        #1;
        checkOutput("axiReqPulse", 32'(bus.axi_req_o), 32'd1);
        checkOutput("axiAddr", bus.axi_addr_o, {addr[31:5], 5'b0});
        tick();
        checkOutput("axiReqOnce", 32'(bus.axi_req_o), 32'd0);
        checkOutput("refillStall", 32'(bus.icache_stall_o), 32'd1);
        tick();
        bus.axi_rend_i = 1'b1;
        bus.axi_data_i = makeLine(base);
        bus.inv_all_i  = invAtRend;
        tick();
        bus.axi_rend_i = 1'b0;
        bus.inv_all_i  = 1'b0;
        #1;
        checkOutput("respValid", 32'(bus.if_rvalid_o), 32'd1);
        checkOutput("respData", bus.if_rdata_o, expWord);
        checkOutput("respNoStall", 32'(bus.icache_stall_o), 32'd0);
        applyStimulus(1'b0, addr);
        for (int h = 0; h < holdCycles; h++) begin
            bus.if_stall_i = 1'b1;
            tick();
            checkOutput("holdValid", 32'(bus.if_rvalid_o), 32'd1);
            checkOutput("holdData", bus.if_rdata_o, expWord);
        end
        bus.if_stall_i = 1'b0;
        tick();
        checkOutput("backToLookup", 32'(bus.if_rvalid_o), 32'd0);
    endtask

    initial begin
        areset              = 1'b1;
        bus.if_req_i        = 1'b0;
        bus.if_addr_i       = '0;
        bus.if_cached_i     = 1'b1;
        bus.if_stall_i      = 1'b0;
        bus.inv_all_i       = 1'b0;
        bus.axi_rend_i      = 1'b0;
        bus.axi_data_i      = '0;
        bus.dcache_active_i = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        #1;
        checkOutput("rstValid", 32'(bus.if_rvalid_o), 32'd0);
        checkOutput("rstStall", 32'(bus.icache_stall_o), 32'd0);
        checkOutput("rstAxiReq", 32'(bus.axi_req_o), 32'd0);
        checkOutput("rstAxiAddr", bus.axi_addr_o, 32'd0);
        checkOutput("rstData", bus.if_rdata_o, 32'd0);

        // Uncached fetch is ignored entirely.
        applyStimulus(1'b1, 32'h1FC0_0024);
        bus.if_cached_i = 1'b0;
        #1;
        checkOutput("uncachedValid", 32'(bus.if_rvalid_o), 32'd0);
        checkOutput("uncachedStall", 32'(bus.icache_stall_o), 32'd0);
        tick();
        checkOutput("uncachedNoReq", 32'(bus.axi_req_o), 32'd0);
        applyStimulus(1'b0, 32'h0);

        // Cold miss, then hit in the same line.
        doMiss(32'h1FC0_0024, 32'hA0, 0, 1'b0, 0);
        doHit(32'h1FC0_0038, 32'hA6);

        // LRU: way1 gets evicted after way0 is re-used.
        doMiss(32'h0000_0000, 32'h100, 0, 1'b0, 0);
        doMiss(32'h0001_0000, 32'h200, 0, 1'b0, 0);
        doHit(32'h0000_0000, 32'h100);
        doMiss(32'h0002_0000, 32'h300, 0, 1'b0, 0);
        doHit(32'h0000_0000, 32'h100);
        doHit(32'h0002_0000, 32'h300);
        doMiss(32'h0001_0000, 32'h400, 0, 1'b0, 0);

        // dcache owns the bus for 5 cycles.
        doMiss(32'h0000_1040, 32'h500, 5, 1'b0, 0);

        // Invalidate together with refill end: word returned, line not kept.
        doMiss(32'h0000_2064, 32'h600, 0, 1'b1, 0);
        doMiss(32'h0000_2064, 32'h700, 0, 1'b0, 0);

        // Response held for 3 stalled cycles.
        doMiss(32'h0000_3000, 32'h800, 0, 1'b0, 3);
        doHit(32'h0000_3004, 32'h801);

        // Reset in the middle of a refill.
        applyStimulus(1'b1, 32'h0000_4008);
        tick();
        applyStimulus(1'b0, 32'h0000_4008);
        #1;
        checkOutput("preRstAxiReq", 32'(bus.axi_req_o), 32'd1);
        areset = 1'b1;
        tick();
        checkOutput("midRstValid", 32'(bus.if_rvalid_o), 32'd0);
        checkOutput("midRstStall", 32'(bus.icache_stall_o), 32'd0);
        checkOutput("midRstAxiReq", 32'(bus.axi_req_o), 32'd0);
        checkOutput("midRstAxiAddr", bus.axi_addr_o, 32'd0);
        checkOutput("midRstData", bus.if_rdata_o, 32'd0);
        areset = 1'b0;
        doMiss(32'h0000_3000, 32'h900, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
